traceback_engine: RTL

TRACEBACK_ENGINE -- requirements
Module: traceback_engine

---
 rtl/design_variables.sv | 34 +++
 rtl/traceback_engine_if.sv | 38 +++
 rtl/tb_step_calc.sv | 60 ++++++
 rtl/traceback_engine.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/design_variables.sv
// ============================================================================
// Module      : design_variables
// Description : Shared widths, direction codes and traceback state encoding
// Revision    : 1.0
// ============================================================================
`default_nettype none

package design_variables;

    localparam int ROW_BITS_WIDTH = 6;
    localparam int COL_BITS_WIDTH = 6;
    localparam int TB_LEN_W       = 6;

    // 62 records already emitted means the one being decoded is the 63rd.
    localparam logic [TB_LEN_W-1:0] TB_LEN_CAP = TB_LEN_W'(62);

    typedef enum logic [1:0] {
        TB_STOP = 2'b00,
        TB_DIAG = 2'b01,
        TB_UP   = 2'b10,
        TB_LEFT = 2'b11
    } tb_dir_t;

    typedef enum logic [2:0] {
        TB_IDLE   = 3'd0,
        TB_FETCH  = 3'd1,
        TB_DECODE = 3'd2,
        TB_EMIT   = 3'd3,
        TB_DONE   = 3'd4
    } tb_state_t;

endpackage

`default_nettype wire

// File: rtl/traceback_engine_if.sv
// ============================================================================
// Module      : traceback_engine_if
// Description : Alignment record stream (valid/ready) from the traceback engine
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface traceback_engine_if;
    import design_variables::*;

    logic                      out_valid;
    logic                      out_ready;
    logic [1:0]                out_op;
    logic [ROW_BITS_WIDTH-1:0] out_row;
    logic [COL_BITS_WIDTH-1:0] out_col;
    logic                      out_last;

    modport master (
        output out_valid,
        output out_op,
        output out_row,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_op,
        input  out_row,
        input  out_col,
        input  out_last,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/tb_step_calc.sv
// ============================================================================
// Module      : tb_step_calc
// Description : Next-cell coordinates and end-of-path flag for one traceback step
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_step_calc
    import design_variables::*;
(
    input  logic [ROW_BITS_WIDTH-1:0] row,
    input  logic [COL_BITS_WIDTH-1:0] col,
    input  tb_dir_t                   dir,
    input  logic [TB_LEN_W-1:0]       tb_len,
    output logic [ROW_BITS_WIDTH-1:0] step_row,
    output logic [COL_BITS_WIDTH-1:0] step_col,
    output logic                      is_last
);

    localparam logic [ROW_BITS_WIDTH-1:0] c_row_one = ROW_BITS_WIDTH'(1);
    localparam logic [COL_BITS_WIDTH-1:0] c_col_one = COL_BITS_WIDTH'(1);

    logic w_row_zero;
    logic w_col_zero;
    logic w_edge;

    assign w_row_zero = (row == '0);
    assign w_col_zero = (col == '0);

    // A move that would leave the matrix ends the path instead of wrapping.
    always_comb begin
        step_row = row;
        step_col = col;
        w_edge   = 1'b0;
        case (dir)
            TB_STOP: w_edge = 1'b1;
            TB_DIAG: begin
                if (w_row_zero || w_col_zero) begin
                    w_edge = 1'b1;
                end else begin
                    step_row = row - c_row_one;
                    step_col = col - c_col_one;
                end
            end
            TB_UP: begin
                if (w_row_zero) w_edge   = 1'b1;
                else            step_row = row - c_row_one;
            end
            TB_LEFT: begin
                if (w_col_zero) w_edge   = 1'b1;
                else            step_col = col - c_col_one;
            end
            default: w_edge = 1'b1;
        endcase
        is_last = w_edge || (tb_len == TB_LEN_CAP);
    end

endmodule

`default_nettype wire

// File: rtl/traceback_engine.sv
// ============================================================================
// Module      : traceback_engine
// Description : Walks the direction matrix from the max cell, emitting records
// Revision    : 1.0
// ============================================================================
`default_nettype none

module traceback_engine
    import design_variables::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_traceback,
    input  logic                      start_of_traceback,
    input  logic [ROW_BITS_WIDTH-1:0] max_row,
    input  logic [COL_BITS_WIDTH-1:0] max_col,
    input  logic [1:0]                dir_in,
    output logic [ROW_BITS_WIDTH-1:0] next_row,
    output logic [COL_BITS_WIDTH-1:0] next_col,
    output logic                      finished,
    output logic [TB_LEN_W-1:0]       tb_len,
    traceback_engine_if.master        rec
);

    localparam logic [TB_LEN_W-1:0] c_len_one = TB_LEN_W'(1);

    tb_state_t                 r_state;
    tb_state_t                 w_state_next;
    logic [ROW_BITS_WIDTH-1:0] r_next_row;
    logic [COL_BITS_WIDTH-1:0] r_next_col;
    logic [TB_LEN_W-1:0]       r_tb_len;
    logic                      r_out_valid;
    tb_dir_t                   r_out_op;
    logic [ROW_BITS_WIDTH-1:0] r_out_row;
    logic [COL_BITS_WIDTH-1:0] r_out_col;
    logic                      r_out_last;

    logic                      w_start;
    logic                      w_abort;
    logic                      w_handshake;
    logic                      w_finished;
    tb_dir_t                   w_calc_dir;
    logic [ROW_BITS_WIDTH-1:0] w_step_row;
    logic [COL_BITS_WIDTH-1:0] w_step_col;
    logic                      w_is_last;

    assign w_start     = start_of_traceback && en_traceback;
    assign w_abort     = (r_state != TB_IDLE) && !en_traceback;
    assign w_handshake = (r_state == TB_EMIT) && r_out_valid && rec.out_ready;

    // DECODE evaluates the fresh memory code; EMIT steps by the held record op.
    assign w_calc_dir = (r_state == TB_DECODE) ? tb_dir_t'(dir_in) : r_out_op;

    tb_step_calc u_step (
        .row      (r_next_row),
        .col      (r_next_col),
        .dir      (w_calc_dir),
        .tb_len   (r_tb_len),
        .step_row (w_step_row),
        .step_col (w_step_col),
        .is_last  (w_is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= TB_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_finished   = 1'b0;
        case (r_state)
            TB_IDLE:   if (w_start) w_state_next = TB_FETCH;
            TB_FETCH:  w_state_next = TB_DECODE;
            TB_DECODE: w_state_next = TB_EMIT;
            TB_EMIT: begin
                if (w_handshake) w_state_next = r_out_last ? TB_DONE : TB_FETCH;
            end
            TB_DONE: begin
                w_finished   = 1'b1;
                w_state_next = TB_IDLE;
            end
            default:   w_state_next = TB_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = TB_IDLE;
            w_finished   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_row  <= '0;
            r_next_col  <= '0;
            r_tb_len    <= '0;
            r_out_valid <= 1'b0;
            r_out_op    <= TB_STOP;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_abort) begin
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                TB_IDLE: begin
                    if (w_start) begin
                        r_next_row <= max_row;
                        r_next_col <= max_col;
                        r_tb_len   <= '0;
                    end
                end
                TB_DECODE: begin
                    r_out_op    <= tb_dir_t'(dir_in);
                    r_out_row   <= r_next_row;
                    r_out_col   <= r_next_col;
                    r_out_last  <= w_is_last;
                    r_out_valid <= 1'b1;
                end
                TB_EMIT: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_tb_len    <= r_tb_len + c_len_one;
                        if (!r_out_last) begin
                            r_next_row <= w_step_row;
                            r_next_col <= w_step_col;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign next_row      = r_next_row;
    assign next_col      = r_next_col;
    assign tb_len        = r_tb_len;
    assign finished      = w_finished;
    assign rec.out_valid = r_out_valid;
    assign rec.out_op    = r_out_op;
    assign rec.out_row   = r_out_row;
    assign rec.out_col   = r_out_col;
    assign rec.out_last  = r_out_last;

endmodule

`default_nettype wire
